// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store memory access unit: control word layout,
// size encodings, exception codes and FSM state encoding.
package mem_access_unit_pkg;

    localparam int CTRL_READ     = 5;
    localparam int CTRL_WRITE    = 4;
    localparam int CTRL_SIZE_MSB = 3;
    localparam int CTRL_SIZE_LSB = 1;
    localparam int CTRL_UNSIGNED = 0;

    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ALIGN   = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: byte-enable generation, store-data lane replication,
// and load lane extraction with zero/sign extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter  int NB_DATA  = 32,
    localparam int NB_BYTES = NB_DATA / 8,
    localparam int NB_OFF   = $clog2(NB_BYTES)
) (
    input  logic [2:0]          size,
    input  logic [NB_OFF-1:0]   offset,
    input  logic                zero_ext,
    input  logic [NB_DATA-1:0]  store_data,
    input  logic [NB_DATA-1:0]  load_word,
    output logic [NB_BYTES-1:0] byte_en,
    output logic [NB_DATA-1:0]  store_lanes,
    output logic [NB_DATA-1:0]  load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en = '0;
        case (size)
            SIZE_BYTE: byte_en = NB_BYTES'(1) << offset;
            SIZE_HALF: byte_en = NB_BYTES'(3) << offset;
            SIZE_WORD: byte_en = '1;
            default:   byte_en = '0;
        endcase
    end

    // Every lane gets a copy so the memory only has to honour the byte enables.
    always_comb begin
        store_lanes = store_data;
        for (int i = 0; i < NB_BYTES; i++) begin
            if (size == SIZE_BYTE) begin
                store_lanes[8*i +: 8] = store_data[7:0];
            end else if (size == SIZE_HALF) begin
                store_lanes[8*i +: 8] = (i % 2 == 1) ? store_data[15:8] : store_data[7:0];
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        sel_half = '0;
        for (int i = 0; i < NB_BYTES; i++) begin
            if (offset == NB_OFF'(i)) sel_byte = load_word[8*i +: 8];
        end
        for (int i = 0; i + 1 < NB_BYTES; i += 2) begin
            if (offset == NB_OFF'(i)) sel_half = load_word[8*i +: 16];
        end
    end

    always_comb begin
        load_data = load_word;
        case (size)
            SIZE_BYTE: begin
                load_data       = {NB_DATA{~zero_ext & sel_byte[7]}};
                load_data[7:0]  = sel_byte;
            end
            SIZE_HALF: begin
                load_data       = {NB_DATA{~zero_ext & sel_half[15]}};
                load_data[15:0] = sel_half;
            end
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-facing load/store unit: validates and aligns a request, drives a simple
// req/ready memory handshake with a bounded wait, and returns the extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int NB_DATA     = 32,
    parameter  int NB_ADDR     = 9,
    parameter  int NB_MEM_CTRL = 6,
    parameter  int TIMEOUT     = 15,
    localparam int NB_BYTES    = NB_DATA / 8,
    localparam int NB_OFF      = $clog2(NB_BYTES),
    localparam int NB_WADDR    = NB_ADDR - NB_OFF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [NB_ADDR-1:0]     addr_i,
    input  logic [NB_DATA-1:0]     data_write_i,
    input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
    output logic                   stall_o,
    output logic                   done_o,
    output logic [NB_DATA-1:0]     data_read_o,
    output logic [1:0]             exc_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [NB_WADDR-1:0]    mem_addr_o,
    output logic [NB_BYTES-1:0]    mem_be_o,
    output logic [NB_DATA-1:0]     mem_wdata_o,
    input  logic [NB_DATA-1:0]     mem_rdata_i,
    input  logic                   mem_ready_i
);

    localparam int NB_CNT = $clog2(TIMEOUT + 1);

    state_t state, next_state;

    logic              req_rd, req_wr, req_uns;
    logic [2:0]        req_size;
    logic [NB_OFF-1:0] req_off;
    logic              size_ok, aligned, req_legal, accept, reject;

    logic [NB_WADDR-1:0] addr_q;
    logic [NB_OFF-1:0]   off_q;
    logic [2:0]          size_q;
    logic                uns_q, we_q;
    logic [NB_DATA-1:0]  wdata_q, data_read_q, load_ext;
    logic [1:0]          exc_q;
    logic [NB_CNT-1:0]   wait_cnt;
    logic                timeout_hit;

    always_comb begin
        req_rd   = MEM_control_i[CTRL_READ];
        req_wr   = MEM_control_i[CTRL_WRITE];
        req_uns  = MEM_control_i[CTRL_UNSIGNED];
        req_size = MEM_control_i[CTRL_SIZE_MSB:CTRL_SIZE_LSB];
        req_off  = addr_i[NB_OFF-1:0];
        size_ok  = 1'b0;
        aligned  = 1'b0;
        case (req_size)
            SIZE_BYTE: begin size_ok = 1'b1; aligned = 1'b1;           end
            SIZE_HALF: begin size_ok = 1'b1; aligned = ~req_off[0];    end
            SIZE_WORD: begin size_ok = 1'b1; aligned = (req_off == '0); end
            default:   begin size_ok = 1'b0; aligned = 1'b0;           end
        endcase
        req_legal = (req_rd ^ req_wr) & size_ok & aligned;
        accept    = (state == ST_IDLE) & valid_i & req_legal;
        reject    = (state == ST_IDLE) & valid_i & (req_rd | req_wr) & ~req_legal;
    end

    assign timeout_hit = (wait_cnt == NB_CNT'(TIMEOUT));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Ready is checked before the timeout so a late ready on the last allowed cycle still completes.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (mem_ready_i)      next_state = ST_DONE;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o   = accept | (state == ST_ACCESS);
        mem_req_o = (state == ST_ACCESS);
        done_o    = (state == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            data_read_q <= '0;
            exc_q       <= EXC_NONE;
            wait_cnt    <= '0;
        end else begin
            exc_q <= EXC_NONE;
            if (reject) exc_q <= EXC_ALIGN;
            if (state == ST_ACCESS && !mem_ready_i && timeout_hit) exc_q <= EXC_TIMEOUT;

            if (accept) begin
                addr_q   <= addr_i[NB_ADDR-1:NB_OFF];
                off_q    <= req_off;
                size_q   <= req_size;
                uns_q    <= req_uns;
                we_q     <= req_wr;
                wdata_q  <= data_write_i;
                wait_cnt <= '0;
            end else if (state == ST_ACCESS) begin
                if (mem_ready_i) begin
                    if (!we_q) data_read_q <= load_ext;
                end else if (!timeout_hit) begin
                    wait_cnt <= wait_cnt + NB_CNT'(1);
                end
            end
        end
    end

    mem_lane_align #(.NB_DATA(NB_DATA)) u_lane_align (
        .size        (size_q),
        .offset      (off_q),
        .zero_ext    (uns_q),
        .store_data  (wdata_q),
        .load_word   (mem_rdata_i),
        .byte_en     (mem_be_o),
        .store_lanes (mem_wdata_o),
        .load_data   (load_ext)
    );

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign data_read_o = data_read_q;
    assign exc_o       = exc_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter NB_DATA, default 32, data word width; SHALL be a multiple of 8, at least 16.
REQ-002 Parameter NB_ADDR, default 9, byte address width; word index = upper NB_ADDR-log2(NB_DATA/8) bits.
REQ-003 Parameter NB_MEM_CTRL, default 6, control word width.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles waiting for mem_ready_i.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 valid_i  in  1  pipeline request strobe.
REQ-008 addr_i  in  NB_ADDR  byte address.
REQ-009 data_write_i  in  NB_DATA  store data, right-justified.
REQ-010 MEM_control_i  in  NB_MEM_CTRL  bit5 read, bit4 write, bits3:1 size one-hot (001 byte, 010 half, 100 word), bit0 unsigned (1 = zero-extend).
REQ-011 stall_o  out  1  pipeline must hold.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 data_read_o  out  NB_DATA  aligned, extended load result.
REQ-014 exc_o  out  2  one-cycle pulse: 01 misaligned/illegal, 10 timeout.
REQ-015 mem_req_o, mem_we_o  out  1 each  memory request, write qualifier.
REQ-016 mem_addr_o  out  NB_ADDR-log2(NB_DATA/8)  word address.
REQ-017 mem_be_o  out  NB_DATA/8  byte-lane enables.
REQ-018 mem_wdata_o  out  NB_DATA  lane-replicated store data.
REQ-019 mem_rdata_i  in  NB_DATA; mem_ready_i  in  1  memory completion, rdata valid same cycle.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE.
REQ-021 IDLE: valid_i with exactly one of read/write, legal one-hot size, aligned offset -> register addr, control, lane-replicated data, byte enables; go ACCESS.
REQ-022 Alignment: half requires offset bit0 = 0; word requires offset = 0; byte always aligned.
REQ-023 IDLE: valid_i with misaligned, illegal size, or both read and write set -> exc_o = 01 next cycle, no memory request, stay IDLE.
REQ-024 IDLE: valid_i with neither read nor write -> ignored, no stall.
REQ-025 stall_o = 1 combinationally in IDLE when a legal request is presented, and throughout ACCESS; 0 in DONE and otherwise.
REQ-026 ACCESS: mem_req_o = 1, addr/be/wdata/we held stable until mem_ready_i.
REQ-027 Byte enables: byte -> 1<<offset; half -> 2'b11<<offset; word -> all ones.
REQ-028 Store data: byte replicated to every lane; half replicated to every half-lane; word unchanged.
REQ-029 ACCESS with mem_ready_i: load selects lane(s) by registered offset, zero- or sign-extends per bit0, registers into data_read_o; go DONE.
REQ-030 Wait counter clears on ACCESS entry, increments each non-ready cycle; at TIMEOUT without ready -> drop mem_req_o, exc_o = 10 next cycle, IDLE, data_read_o unchanged.
REQ-031 mem_ready_i on the cycle the counter reaches TIMEOUT -> ready wins; normal completion.
REQ-032 DONE: done_o = 1 for one cycle; return to IDLE; data_read_o held until next completed load; stores leave data_read_o unchanged.
REQ-033 mem_ready_i outside ACCESS SHALL be ignored.
REQ-034 Minimum latency: request accepted cycle N, ready at N+1 -> done_o at N+2.

Reset
REQ-035 reset_i SHALL immediately force IDLE and clear all outputs and registers to 0, including mid-ACCESS (request abandoned, no done_o, no exc_o).

Structure
REQ-036 Shared package: control bit indices, size encodings, exc_o codes, FSM state encoding.
REQ-037 One sub-module, mem_lane_align: combinational lane extraction/extension and replication/byte-enable generation.

Verification
REQ-038 LB signed, addr 0x003, rdata 0x80000000, ready after 2 cycles -> data_read_o 0xFFFFFF80, done_o at cycle 4.
REQ-039 SH addr 0x002, data 0x0000BEEF -> mem_be_o 1100, mem_wdata_o 0xBEEFBEEF, mem_we_o 1.
REQ-040 LW addr 0x001 -> exc_o 01 one cycle, mem_req_o never asserted.
REQ-041 LHU addr 0x006, ready never -> after 15 wait cycles exc_o 10, mem_req_o low, IDLE.
REQ-042 reset_i pulsed during ACCESS -> all outputs 0 asynchronously, no done_o; next request completes normally.
